// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding and default widths.
package pipe_skid_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_occupancy(input skid_state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Control+data payload register with load enable and a control-only clear.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load. Clear wins over load and keeps data.
module pipe_payload_reg
    import pipe_skid_stage_pkg::*;
#(
    parameter int                CTRL_W    = DEF_CTRL_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_KEEP = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    // Data is left untouched on clear so an exception handler can still inspect it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (clear) begin
            ctrl_q <= ctrl_q & CTRL_KEEP;
        end else if (load) begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage (main + skid register) with flush.
// Latency: 1 cycle from upstream accept to out_* when empty.
// Backpressure: in_ready is registered (state != TWO), no combinational path from out_ready.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                CTRL_W    = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_KEEP = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_t       state_q;
    skid_state_t       state_d;
    logic              in_ready_q;

    logic              up_xfer;
    logic              dn_xfer;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;

    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign occupancy = state_occupancy(state_q);
    assign up_xfer   = in_valid & in_ready_q & ~flush;
    assign dn_xfer   = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // Flush overrides everything; a downstream pop in the same cycle is simply absorbed.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_load = 1'b1;
                    end else if (up_xfer) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (dn_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (dn_xfer) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = main_from_skid ? skid_data : in_data;

    pipe_payload_reg #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CTRL_KEEP (CTRL_KEEP)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .load   (main_load),
        .clear  (flush),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .ctrl_q (main_ctrl),
        .data_q (out_data)
    );

    pipe_payload_reg #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CTRL_KEEP (CTRL_KEEP)
    ) u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (skid_load),
        .clear  (flush),
        .ctrl_d (in_ctrl),
        .data_d (in_data),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data)
    );

    // Control is masked while the head is empty so a bubble never carries side effects.
    assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks of pipe_skid_stage with a queue reference model.
module tb_pipe_skid_stage;

    localparam int CW = 2;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_skid_stage #(
        .DATA_W    (DW),
        .CTRL_W    (CW),
        .CTRL_KEEP (2'b10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [CW+DW-1:0] q[$];
    logic             m_up;
    logic             m_dn;

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        tick();
        chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("deassert_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        chk("first_edge_in_ready", 64'(in_ready), 64'd1);

        // Fill then drain
        in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h11;
        tick();
        chk("fill_a_valid", 64'(out_valid), 64'd1);
        chk("fill_a_data",  64'(out_data),  64'h11);
        chk("fill_a_occ",   64'(occupancy), 64'd1);
        chk("fill_a_ctrl",  64'(out_ctrl),  64'd1);
        in_data = 32'h22;
        tick();
        chk("fill_b_occ",      64'(occupancy), 64'd2);
        chk("fill_b_in_ready", 64'(in_ready),  64'd0);
        chk("fill_b_head",     64'(out_data),  64'h11);
        in_valid = 1'b0;
        tick();
        chk("hold_head", 64'(out_data), 64'h11);
        chk("hold_occ",  64'(occupancy), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("drain_a_data", 64'(out_data), 64'h11);
        tick();
        chk("drain_b_data",     64'(out_data),  64'h22);
        chk("drain_b_occ",      64'(occupancy), 64'd1);
        chk("drain_b_in_ready", 64'(in_ready),  64'd1);
        tick();
        chk("drain_empty_valid", 64'(out_valid), 64'd0);
        chk("drain_empty_ctrl",  64'(out_ctrl),  64'd0);
        chk("drain_empty_data",  64'(out_data),  64'h22);

        // Streaming with one-cycle latency
        in_valid = 1'b1; in_ctrl = 2'b01;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'(i);
            tick();
            chk("stream_valid",    64'(out_valid), 64'd1);
            chk("stream_data",     64'(out_data),  64'(i));
            chk("stream_in_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 64'(out_valid), 64'd0);

        // Flush with two held entries, CTRL_KEEP = 2'b10
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data = 32'hDEAD;
        tick();
        tick();
        chk("pre_flush_occ",  64'(occupancy), 64'd2);
        chk("pre_flush_ctrl", 64'(out_ctrl),  64'd3);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid",     64'(out_valid), 64'd0);
        chk("flush_ctrl",      64'(out_ctrl),  64'd0);
        chk("flush_data",      64'(out_data),  64'hDEAD);
        chk("flush_occ",       64'(occupancy), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        chk("flush_kept_ctrl", 64'(dut.u_main.ctrl_q), 64'd2);

        // Entry offered during flush is dropped
        in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h55; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_valid", 64'(out_valid), 64'd0);
        chk("flush_drop_occ",   64'(occupancy), 64'd0);
        tick();
        chk("flush_drop_valid2", 64'(out_valid), 64'd0);
        chk("flush_drop_data",   64'(out_data),  64'hDEAD);

        // Asynchronous reset while in TWO
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h77;
        tick();
        in_data = 32'h88;
        tick();
        in_valid = 1'b0;
        chk("pre_arst_occ", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid",    64'(out_valid), 64'd0);
        chk("arst_occ",      64'(occupancy), 64'd0);
        chk("arst_in_ready", 64'(in_ready),  64'd0);
        chk("arst_data",     64'(out_data),  64'd0);
        chk("arst_ctrl",     64'(out_ctrl),  64'd0);
        reset = 1'b1;
        tick();
        chk("arst_rel_in_ready", 64'(in_ready),  64'd1);
        chk("arst_rel_valid",    64'(out_valid), 64'd0);

        // Random traffic against a queue model
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = $urandom;
            chk("rnd_valid",    64'(out_valid), 64'(q.size() != 0));
            chk("rnd_occ",      64'(occupancy), 64'(q.size()));
            chk("rnd_in_ready", 64'(in_ready),  64'(q.size() != 2));
            if (q.size() != 0) begin
                chk("rnd_data", 64'(out_data), 64'(q[0][DW-1:0]));
                chk("rnd_ctrl", 64'(out_ctrl), 64'(q[0][CW+DW-1:DW]));
            end else begin
                chk("rnd_idle_ctrl", 64'(out_ctrl), 64'd0);
            end
            m_up = in_valid && (q.size() != 2) && !flush;
            m_dn = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_dn) void'(q.pop_front());
                if (m_up) q.push_back({in_ctrl, in_data});
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
